mul_div_unit: RTL and testbench

Multiply/divide unit for the pipelined MIPS core. It sits in the EX stage beside the ALU and owns the HI/LO registers. It executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and MTHI/MTLO in a single cycle. MFHI/MFLO results flow from its HI/LO outputs down the pipeline into the register file write port. Its `busy` output drives the hazard unit, which stalls MD-class instructions in D.

---
 rtl/mdu_pkg.sv | 31 +++
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mdu_arith.sv | 62 ++++++
 rtl/mul_div_unit.sv | 111 +++++++++++
 tb/tb_mul_div_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and the launch-decode helper used by the hazard unit.
package mdu_pkg;

    // Encoding of the MDUOp field; 7 is reserved and behaves as NOP.
    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // True for the operations that occupy the unit for a multi-cycle period.
    function automatic logic is_md_start(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // True for the division operations (selects the longer latency).
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if;

    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side: issues operations, observes busy and HI/LO.
    modport master (
        output start, MDUOp, A, B,
        input  busy, HI, LO
    );

    // Unit side: accepts operations, owns busy and HI/LO.
    modport slave (
        input  start, MDUOp, A, B,
        output busy, HI, LO
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing a {hi, lo} pair.
// A zero divisor is reported separately so the caller can leave HI/LO intact.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic               div_ovf;

    // The low 64 bits of a product of sign-extended operands equal the
    // signed 64-bit product, so both flavours share one unsigned multiplier form.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Substitute 1 for a zero divisor so the dividers never see 0; the
    // result is discarded in that case anyway.
    assign divisor = (b == 32'd0) ? 32'd1 : b;
    assign sa      = $signed(a);
    assign sb      = $signed(divisor);
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign q_s     = sa / sb;
    assign r_s     = sa % sb;
    assign q_u     = a / divisor;
    assign r_u     = a % divisor;

    // Select the result for the requested operation.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result   = '0;
        div_zero = 1'b0;
        case (mdu_op_e'(op))
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV: begin
                div_zero = (b == 32'd0);
                // -2^31 / -1 overflows 32 bits; define it as quotient -2^31, remainder 0.
                if (div_ovf) result = {32'd0, 32'h8000_0000};
                else         result = {r_s, q_s};
            end
            MDU_DIVU: begin
                div_zero = (b == 32'd0);
                result   = {r_u, q_u};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO. MULT/DIV results are computed
// at launch into shadow registers and committed after a fixed busy period;
// MTHI/MTLO write HI/LO directly in one cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] hi_n, lo_n;
    logic        zero_n;
    logic        launch, commit, wr_hi, wr_lo;
    logic [63:0] arith_res;
    logic        arith_div_zero;

    mdu_arith u_arith (
        .op       (bus.MDUOp),
        .a        (bus.A),
        .b        (bus.B),
        .result   (arith_res),
        .div_zero (arith_div_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control decode; starts in BUSY are ignored.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_md_start(bus.MDUOp)) begin
                        launch  = 1'b1;
                        state_d = ST_BUSY;
                    end else if (bus.MDUOp == MDU_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (bus.MDUOp == MDU_MTLO) begin
                        wr_lo = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // Counter reaches zero on this edge: commit and return to IDLE.
                if (cnt_q <= CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latency counter, shadow results and the architectural HI/LO registers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register here is reset, so a reset mid-operation also drops the pending result.
        if (reset) begin
            cnt_q  <= '0;
            hi_n   <= '0;
            lo_n   <= '0;
            zero_n <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (launch) begin
                hi_n   <= arith_res[63:32];
                lo_n   <= arith_res[31:0];
                zero_n <= arith_div_zero;
                cnt_q  <= is_div_op(bus.MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (state_q == ST_BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (commit && !zero_n) begin
                hi_q <= hi_n;
                lo_q <= lo_n;
            end
            if (wr_hi) hi_q <= bus.A;
            if (wr_lo) lo_q <= bus.A;
        end
    end

    assign bus.busy = (state_q == ST_BUSY);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latencies, arithmetic corner cases,
// MTHI/MTLO, ignored start while busy and asynchronous reset.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    mul_div_unit_if bus ();

    mul_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues one mult/div, counts busy cycles, checks HI/LO.
    // Returns at the negedge where busy has fallen, so a following call
    // exercises back-to-back issue with no dead cycle.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          cyc;
        old_hi    = bus.HI;
        old_lo    = bus.LO;
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        check({tag, " busy_rise"}, 32'(bus.busy), 32'd1);
        check({tag, " hold_hi"}, bus.HI, old_hi);
        check({tag, " hold_lo"}, bus.LO, old_lo);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 32'(cyc), 32'(n));
        check({tag, " hi"}, bus.HI, exp_hi);
        check({tag, " lo"}, bus.LO, exp_lo);
    endtask

    // Called at a negedge; issues a single-cycle op and checks HI/LO after the edge.
    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
        check({tag, " hi"}, bus.HI, exp_hi);
        check({tag, " lo"}, bus.LO, exp_lo);
    endtask

    initial begin
        int cyc;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        bus.A     = '0;
        bus.B     = '0;

        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset hi", bus.HI, 32'd0);
        check("reset lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // NOP and reserved encodings do nothing.
        run_mt("nop", MDU_NOP, 32'hDEAD_BEEF, 32'd0, 32'd0);
        run_mt("rsvd", MDU_RSVD, 32'hDEAD_BEEF, 32'd0, 32'd0);

        // Multiplies and divides issued back to back.
        run_md("mult", MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu", MDU_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'h0000_0001, 32'h7FFF_FFFC);
        run_md("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

        // Single-cycle moves.
        run_mt("mtlo", MDU_MTLO, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005);
        run_mt("mthi", MDU_MTHI, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0005);

        // Divide by zero runs the full period and leaves HI/LO; an MTHI
        // issued mid-busy breaks the hazard contract and must be ignored.
        bus.start = 1'b1;
        bus.MDUOp = MDU_DIV;
        bus.A     = 32'd100;
        bus.B     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            if (cyc == 3) begin
                $display("note: MTHI 0x12345678 issued while busy (hazard contract violation, expected to be ignored)");
                bus.start = 1'b1;
                bus.MDUOp = MDU_MTHI;
                bus.A     = 32'h1234_5678;
            end else begin
                bus.start = 1'b0;
                bus.MDUOp = MDU_NOP;
            end
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        check("div0 busy_cycles", 32'(cyc), 32'd10);
        check("div0 hi", bus.HI, 32'hA5A5_A5A5);
        check("div0 lo", bus.LO, 32'h0000_0005);

        // Asynchronous reset during a DIV: state clears between edges, no later commit.
        bus.start = 1'b1;
        bus.MDUOp = MDU_DIV;
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = MDU_NOP;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset busy", 32'(bus.busy), 32'd0);
        check("async_reset hi", bus.HI, 32'd0);
        check("async_reset lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset busy", 32'(bus.busy), 32'd0);
        check("post_reset hi", bus.HI, 32'd0);
        check("post_reset lo", bus.LO, 32'd0);

        // Normal operation resumes after reset: 3 * -4 = -12.
        run_md("mult_after_reset", MDU_MULT, 32'h0000_0003, 32'hFFFF_FFFC, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
